// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
//
// Ports:
//   i_clk, i_rst_n            clock; asynchronous active-low reset
//   i_flush                   synchronous flush, discards held and incoming entries
//   i_mem_valid/o_mem_ready   upstream handshake (o_mem_ready is registered)
//   i_mem_*                   write-back payload from MEM (GPR, HI/LO, LLbit)
//   o_wb_valid/i_wb_ready     downstream handshake
//   o_wb_*                    registered write-back payload; enables gated by o_wb_valid
module mem_wb_skid #(
    parameter int                 DATA_W        = 32,
    parameter int                 ADDR_W        = 5,
    parameter logic [ADDR_W-1:0]  NOP_ADDR      = '0,
    parameter int                 ZERO_SUPPRESS = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic [ADDR_W-1:0] i_mem_waddr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    input  logic              i_mem_wen,
    input  logic              i_mem_hilo_wen,
    input  logic [DATA_W-1:0] i_mem_hi,
    input  logic [DATA_W-1:0] i_mem_lo,
    input  logic              i_mem_llbit_wen,
    input  logic              i_mem_llbit,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic [ADDR_W-1:0] o_wb_waddr,
    output logic [DATA_W-1:0] o_wb_wdata,
    output logic              o_wb_wen,
    output logic              o_wb_hilo_wen,
    output logic [DATA_W-1:0] o_wb_hi,
    output logic [DATA_W-1:0] o_wb_lo,
    output logic              o_wb_llbit_wen,
    output logic              o_wb_llbit
);
    localparam int PW = 3 * DATA_W + ADDR_W + 4;
    localparam logic [PW-1:0] RST_PAYLOAD = {NOP_ADDR, {(PW - ADDR_W){1'b0}}};

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_valid;
    logic          r_ready;
    logic [PW-1:0] r_main;
    logic [PW-1:0] r_skid;
    logic [PW-1:0] w_in;
    logic          w_accept;
    logic          w_emit;
    logic          w_load_main;
    logic          w_load_skid;
    logic          w_sel_skid;

    logic [ADDR_W-1:0] w_waddr;
    logic              w_wen;
    logic              w_hilo_wen;
    logic              w_llbit_wen;

    assign w_in     = {i_mem_waddr, i_mem_wdata, i_mem_wen, i_mem_hilo_wen,
                       i_mem_hi, i_mem_lo, i_mem_llbit_wen, i_mem_llbit};
    assign w_accept = i_mem_valid & r_ready;
    assign w_emit   = r_valid & i_wb_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_sel_skid  = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_load_main = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && !w_emit) begin
                    w_state_nxt = S_TWO;
                    w_load_skid = 1'b1;
                end else if (w_accept && w_emit) begin
                    w_load_main = 1'b1;
                end else if (w_emit) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                // ready is low here, so only the drain of the skid entry can happen
                if (w_emit) begin
                    w_state_nxt = S_ONE;
                    w_load_main = 1'b1;
                    w_sel_skid  = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // flush wins over everything; payload regs are left alone, valid drops
        if (i_flush) begin
            w_state_nxt = S_EMPTY;
            w_load_main = 1'b0;
            w_load_skid = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_main  <= RST_PAYLOAD;
            r_skid  <= RST_PAYLOAD;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt != S_EMPTY);
            r_ready <= (w_state_nxt != S_TWO);
            if (w_load_main)
                r_main <= w_sel_skid ? r_skid : w_in;
            if (w_load_skid)
                r_skid <= w_in;
        end
    end

    assign {w_waddr, o_wb_wdata, w_wen, w_hilo_wen,
            o_wb_hi, o_wb_lo, w_llbit_wen, o_wb_llbit} = r_main;

    assign o_mem_ready    = r_ready;
    assign o_wb_valid     = r_valid;
    assign o_wb_waddr     = w_waddr;
    assign o_wb_wen       = w_wen & r_valid & !((ZERO_SUPPRESS != 0) && (w_waddr == '0));
    assign o_wb_hilo_wen  = w_hilo_wen & r_valid;
    assign o_wb_llbit_wen = w_llbit_wen & r_valid;
endmodule

// File: tb/tb_mem_wb_skid.sv
// tb_mem_wb_skid: directed self-checking bench for mem_wb_skid.
module tb_mem_wb_skid;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_mem_valid = 1'b0;
    logic [4:0]  i_mem_waddr = '0;
    logic [31:0] i_mem_wdata = '0;
    logic        i_mem_wen = 1'b0;
    logic        i_mem_hilo_wen = 1'b0;
    logic [31:0] i_mem_hi = '0;
    logic [31:0] i_mem_lo = '0;
    logic        i_mem_llbit_wen = 1'b0;
    logic        i_mem_llbit = 1'b0;
    logic        i_wb_ready = 1'b0;

    logic        o_mem_ready, o_wb_valid, o_wb_wen, o_wb_hilo_wen, o_wb_llbit_wen, o_wb_llbit;
    logic [4:0]  o_wb_waddr;
    logic [31:0] o_wb_wdata, o_wb_hi, o_wb_lo;

    logic        z_mem_ready, z_wb_valid, z_wb_wen, z_wb_hilo_wen, z_wb_llbit_wen, z_wb_llbit;
    logic [4:0]  z_wb_waddr;
    logic [31:0] z_wb_wdata, z_wb_hi, z_wb_lo;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mem_wb_skid #(.ZERO_SUPPRESS(1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
        .i_mem_waddr(i_mem_waddr), .i_mem_wdata(i_mem_wdata), .i_mem_wen(i_mem_wen),
        .i_mem_hilo_wen(i_mem_hilo_wen), .i_mem_hi(i_mem_hi), .i_mem_lo(i_mem_lo),
        .i_mem_llbit_wen(i_mem_llbit_wen), .i_mem_llbit(i_mem_llbit),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
        .o_wb_waddr(o_wb_waddr), .o_wb_wdata(o_wb_wdata), .o_wb_wen(o_wb_wen),
        .o_wb_hilo_wen(o_wb_hilo_wen), .o_wb_hi(o_wb_hi), .o_wb_lo(o_wb_lo),
        .o_wb_llbit_wen(o_wb_llbit_wen), .o_wb_llbit(o_wb_llbit)
    );

    mem_wb_skid #(.ZERO_SUPPRESS(0)) dut_nz (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_mem_valid(i_mem_valid), .o_mem_ready(z_mem_ready),
        .i_mem_waddr(i_mem_waddr), .i_mem_wdata(i_mem_wdata), .i_mem_wen(i_mem_wen),
        .i_mem_hilo_wen(i_mem_hilo_wen), .i_mem_hi(i_mem_hi), .i_mem_lo(i_mem_lo),
        .i_mem_llbit_wen(i_mem_llbit_wen), .i_mem_llbit(i_mem_llbit),
        .o_wb_valid(z_wb_valid), .i_wb_ready(i_wb_ready),
        .o_wb_waddr(z_wb_waddr), .o_wb_wdata(z_wb_wdata), .o_wb_wen(z_wb_wen),
        .o_wb_hilo_wen(z_wb_hilo_wen), .o_wb_hi(z_wb_hi), .o_wb_lo(z_wb_lo),
        .o_wb_llbit_wen(z_wb_llbit_wen), .o_wb_llbit(z_wb_llbit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic we);
        i_mem_valid = v;
        i_mem_waddr = a;
        i_mem_wdata = d;
        i_mem_wen   = we;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, {31'd0, o_wb_valid}, 32'd0);
        chk({tag, ".ready"}, {31'd0, o_mem_ready}, 32'd1);
        chk({tag, ".wen"}, {31'd0, o_wb_wen}, 32'd0);
        chk({tag, ".hilo_wen"}, {31'd0, o_wb_hilo_wen}, 32'd0);
        chk({tag, ".llbit_wen"}, {31'd0, o_wb_llbit_wen}, 32'd0);
    endtask

    initial begin
        // reset held
        tick();
        tick();
        chk_idle("rst");
        chk("rst.waddr", {27'd0, o_wb_waddr}, 32'd0);
        chk("rst.wdata", o_wb_wdata, 32'd0);
        i_rst_n = 1'b1;
        tick();
        chk_idle("rel");
        chk("rel.waddr", {27'd0, o_wb_waddr}, 32'd0);

        // streaming
        i_wb_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 5'(i), 32'h11 * i, 1'b1);
            tick();
            chk($sformatf("strm%0d.valid", i), {31'd0, o_wb_valid}, 32'd1);
            chk($sformatf("strm%0d.waddr", i), {27'd0, o_wb_waddr}, i);
            chk($sformatf("strm%0d.wdata", i), o_wb_wdata, 32'h11 * i);
            chk($sformatf("strm%0d.wen", i), {31'd0, o_wb_wen}, 32'd1);
            chk($sformatf("strm%0d.ready", i), {31'd0, o_mem_ready}, 32'd1);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        chk("strm.drain", {31'd0, o_wb_valid}, 32'd0);

        // backpressure
        i_wb_ready = 1'b0;
        drive(1'b1, 5'd10, 32'hA5, 1'b1);
        tick();
        chk("bp.A.valid", {31'd0, o_wb_valid}, 32'd1);
        chk("bp.A.wdata", o_wb_wdata, 32'hA5);
        chk("bp.A.ready", {31'd0, o_mem_ready}, 32'd1);
        drive(1'b1, 5'd11, 32'h5A, 1'b1);
        tick();
        chk("bp.full.ready", {31'd0, o_mem_ready}, 32'd0);
        chk("bp.full.wdata", o_wb_wdata, 32'hA5);
        drive(1'b1, 5'd12, 32'h77, 1'b1);
        tick();
        chk("bp.hold.wdata", o_wb_wdata, 32'hA5);
        chk("bp.hold.waddr", {27'd0, o_wb_waddr}, 32'd10);
        chk("bp.hold.wen", {31'd0, o_wb_wen}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        i_wb_ready = 1'b1;
        tick();
        chk("bp.B.valid", {31'd0, o_wb_valid}, 32'd1);
        chk("bp.B.wdata", o_wb_wdata, 32'h5A);
        chk("bp.B.waddr", {27'd0, o_wb_waddr}, 32'd11);
        chk("bp.B.ready", {31'd0, o_mem_ready}, 32'd1);
        tick();
        chk("bp.empty", {31'd0, o_wb_valid}, 32'd0);

        // flush in TWO with incoming valid
        i_wb_ready = 1'b0;
        drive(1'b1, 5'd3, 32'hC1, 1'b1);
        tick();
        drive(1'b1, 5'd4, 32'hC2, 1'b1);
        tick();
        chk("fl.two.ready", {31'd0, o_mem_ready}, 32'd0);
        drive(1'b1, 5'd5, 32'hC3, 1'b1);
        i_flush = 1'b1;
        tick();
        chk_idle("fl");
        i_flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        i_wb_ready = 1'b1;
        tick();
        chk("fl.after1", {31'd0, o_wb_valid}, 32'd0);
        tick();
        chk("fl.after2", {31'd0, o_wb_valid}, 32'd0);

        // zero-address write suppression
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1);
        tick();
        chk("zs1.valid", {31'd0, o_wb_valid}, 32'd1);
        chk("zs1.wen", {31'd0, o_wb_wen}, 32'd0);
        chk("zs1.wdata", o_wb_wdata, 32'hDEAD);
        chk("zs0.valid", {31'd0, z_wb_valid}, 32'd1);
        chk("zs0.wen", {31'd0, z_wb_wen}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        tick();

        // HI/LO and LLbit
        drive(1'b1, 5'd6, 32'h0, 1'b0);
        i_mem_hilo_wen  = 1'b1;
        i_mem_hi        = 32'h1234;
        i_mem_lo        = 32'h5678;
        i_mem_llbit_wen = 1'b1;
        i_mem_llbit     = 1'b1;
        tick();
        chk("hl.valid", {31'd0, o_wb_valid}, 32'd1);
        chk("hl.hilo_wen", {31'd0, o_wb_hilo_wen}, 32'd1);
        chk("hl.hi", o_wb_hi, 32'h1234);
        chk("hl.lo", o_wb_lo, 32'h5678);
        chk("hl.llbit_wen", {31'd0, o_wb_llbit_wen}, 32'd1);
        chk("hl.llbit", {31'd0, o_wb_llbit}, 32'd1);
        chk("hl.wen", {31'd0, o_wb_wen}, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        i_mem_hilo_wen  = 1'b0;
        i_mem_llbit_wen = 1'b0;
        tick();
        chk_idle("hl.gate");

        // reset mid-transfer
        i_wb_ready = 1'b0;
        drive(1'b1, 5'd7, 32'hE1, 1'b1);
        tick();
        drive(1'b1, 5'd8, 32'hE2, 1'b1);
        tick();
        chk("mr.full", {31'd0, o_mem_ready}, 32'd0);
        #2 i_rst_n = 1'b0;
        #1;
        chk_idle("mr");
        chk("mr.waddr", {27'd0, o_wb_waddr}, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("mr.after", {31'd0, o_wb_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
